// File: rtl/dcache_flush_engine.sv
// dcache_flush_engine: walks every cache line, writes dirty lines back to memory, then cleans or invalidates them
module dcache_flush_engine #(
    parameter int NUM_SETS = 16,
    parameter int NUM_WAYS = 2,
    parameter int LINE_W   = 256,
    parameter int TAG_W    = 25,
    parameter int ADDR_W   = 32,
    localparam int IDX_W = $clog2(NUM_SETS),
    localparam int WAY_W = NUM_WAYS > 1 ? $clog2(NUM_WAYS) : 1,
    localparam int CNT_W = $clog2(NUM_SETS * NUM_WAYS) + 1,
    localparam int OFF_W = $clog2(LINE_W / 8)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_req_i,
    input  logic              flush_inv_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  wb_count_o,
    output logic [IDX_W-1:0]  sram_idx_o,
    output logic [WAY_W-1:0]  sram_way_o,
    input  logic [TAG_W-1:0]  sram_tag_i,
    input  logic [LINE_W-1:0] sram_data_i,
    output logic              sram_tag_we_o,
    output logic [TAG_W-1:0]  sram_tag_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic              mem_ack_i
);
    typedef enum logic [2:0] {IDLE, SCAN, WRITE, CLEAR, DONE} state_t;
    state_t state, next;
    logic [IDX_W-1:0] idx;
    logic [WAY_W-1:0] way;
    logic [CNT_W-1:0] wb_count;
    logic inv, valid, dirty, last, advance;
    assign valid = sram_tag_i[TAG_W-1];
    assign dirty = sram_tag_i[TAG_W-2];
    assign last = idx == IDX_W'(NUM_SETS - 1) && way == WAY_W'(NUM_WAYS - 1);
    // a line is finished either straight from SCAN (nothing to do) or after its CLEAR
    assign advance = (state == SCAN && (!valid || (!dirty && !inv))) || state == CLEAR;
    assign sram_idx_o = idx;
    assign sram_way_o = way;
    assign wb_count_o = wb_count;
    always_ff @(posedge clk_i) begin
        if (!rst_i) state <= IDLE;
        else state <= next;
    end
    always_comb begin
        next = state;
        unique case (state)
            IDLE:  next = flush_req_i ? SCAN : IDLE;
            SCAN:  next = valid && dirty ? WRITE : valid && inv ? CLEAR : last ? DONE : SCAN;
            WRITE: next = mem_ack_i ? CLEAR : WRITE;
            CLEAR: next = last ? DONE : SCAN;
            DONE:  next = IDLE;
            default: next = IDLE;
        endcase
    end
    always_comb begin
        busy_o = state != IDLE;
        done_o = state == DONE;
        mem_enable_o = state == WRITE;
        mem_write_o = state == WRITE;
        sram_tag_we_o = state == CLEAR;
        sram_tag_o = state == CLEAR ? {valid & ~inv, 1'b0, sram_tag_i[TAG_W-3:0]} : '0;
    end
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            idx <= '0;
            way <= '0;
            inv <= 1'b0;
            wb_count <= '0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
        end else begin
            if (state == IDLE && flush_req_i) begin
                idx <= '0;
                way <= '0;
                inv <= flush_inv_i;
                wb_count <= '0;
            end
            if (advance) begin
                idx <= idx + 1'b1;
                if (idx == IDX_W'(NUM_SETS - 1))
                    way <= way == WAY_W'(NUM_WAYS - 1) ? '0 : way + 1'b1;
            end
            if (state == SCAN && valid && dirty) begin
                mem_addr_o <= {sram_tag_i[TAG_W-3:0], idx, {OFF_W{1'b0}}};
                mem_data_o <= sram_data_i;
            end
            if (state == WRITE && mem_ack_i) wb_count <= wb_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_dcache_flush_engine.sv
// tb_dcache_flush_engine: randomized flushes against a line-by-line reference model of the cache walk
module tb_dcache_flush_engine;
    localparam int NUM_SETS = 16;
    localparam int NUM_WAYS = 2;
    localparam int LINE_W = 256;
    localparam int TAG_W = 25;
    localparam int ADDR_W = 32;
    localparam int N = NUM_SETS * NUM_WAYS;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_i = 1'b0, flush_req_i = 1'b0, flush_inv_i = 1'b0, mem_ack_i = 1'b0;
    logic busy_o, done_o, sram_tag_we_o, mem_enable_o, mem_write_o;
    logic [5:0] wb_count_o;
    logic [3:0] sram_idx_o;
    logic [0:0] sram_way_o;
    logic [TAG_W-1:0] sram_tag_i, sram_tag_o;
    logic [LINE_W-1:0] sram_data_i, mem_data_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [TAG_W-1:0] tags [NUM_WAYS][NUM_SETS];
    logic [LINE_W-1:0] lines [NUM_WAYS][NUM_SETS];
    logic [ADDR_W-1:0] exp_addr [$];
    logic [LINE_W-1:0] exp_data [$];
    int n_checks = 0, n_errors = 0;
    int cyc, n_busy, n_done, n_en, done_at, run, ack_d;
    bit stray, chk_wr;
    assign sram_tag_i = tags[sram_way_o][sram_idx_o];
    assign sram_data_i = lines[sram_way_o][sram_idx_o];
    dcache_flush_engine dut (
        .clk_i(clk), .rst_i(rst_i), .flush_req_i(flush_req_i), .flush_inv_i(flush_inv_i),
        .busy_o(busy_o), .done_o(done_o), .wb_count_o(wb_count_o),
        .sram_idx_o(sram_idx_o), .sram_way_o(sram_way_o), .sram_tag_i(sram_tag_i),
        .sram_data_i(sram_data_i), .sram_tag_we_o(sram_tag_we_o), .sram_tag_o(sram_tag_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_ack_i(mem_ack_i)
    );
    logic req2 = 1'b0, ack2 = 1'b0;
    logic busy2, done2, we2, en2, wr2;
    logic [5:0] wb2;
    logic [2:0] idx2;
    logic [1:0] way2;
    logic [25:0] tag2_in = '0, tag2_out;
    logic [LINE_W-1:0] data2_in = '0, data2_out;
    logic [31:0] addr2;
    dcache_flush_engine #(.NUM_SETS(8), .NUM_WAYS(4), .TAG_W(26)) dut2 (
        .clk_i(clk), .rst_i(rst_i), .flush_req_i(req2), .flush_inv_i(1'b0),
        .busy_o(busy2), .done_o(done2), .wb_count_o(wb2), .sram_idx_o(idx2), .sram_way_o(way2),
        .sram_tag_i(tag2_in), .sram_data_i(data2_in), .sram_tag_we_o(we2), .sram_tag_o(tag2_out),
        .mem_enable_o(en2), .mem_write_o(wr2), .mem_addr_o(addr2), .mem_data_o(data2_out),
        .mem_ack_i(ack2)
    );
    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic fill(input int pv, input int pd);
        for (int w = 0; w < NUM_WAYS; w++)
            for (int s = 0; s < NUM_SETS; s++) begin
                tags[w][s] = {1'($urandom_range(0, 99) < pv), 1'($urandom_range(0, 99) < pd), 23'($urandom)};
                lines[w][s] = {8{$urandom}};
            end
    endtask
    // one cycle of the environment: SRAM tag write, memory responder, activity counters
    task automatic step();
        @(negedge clk);
        cyc++;
        if (sram_tag_we_o) tags[sram_way_o][sram_idx_o] = sram_tag_o;
        if (busy_o) n_busy++;
        if (done_o) begin
            n_done++;
            if (done_at < 0) done_at = cyc;
        end
        if (mem_enable_o) begin
            n_en++;
            run++;
            mem_ack_i = run == ack_d;
            if (mem_ack_i && chk_wr) begin
                check("wr_flag", mem_write_o, 1);
                if (exp_addr.size() == 0) check("extra_write", mem_addr_o, 0);
                else begin
                    check("wr_addr", mem_addr_o, exp_addr.pop_front());
                    check("wr_data", mem_data_o, exp_data.pop_front());
                end
            end
        end else begin
            run = 0;
            mem_ack_i = stray && $urandom_range(0, 3) == 0;
        end
    endtask
    task automatic run_flush(input string name, input bit inv, input int d, input bit st, input bit second);
        logic [TAG_W-1:0] exp_tags [NUM_WAYS][NUM_SETS];
        logic [TAG_W-1:0] t;
        int n_dirty = 0, n_ci = 0, exp_done;
        exp_addr.delete();
        exp_data.delete();
        for (int w = 0; w < NUM_WAYS; w++)
            for (int s = 0; s < NUM_SETS; s++) begin
                t = tags[w][s];
                exp_tags[w][s] = t;
                if (t[TAG_W-1] && t[TAG_W-2]) begin
                    n_dirty++;
                    exp_addr.push_back(32'(t[TAG_W-3:0]) * 32'(NUM_SETS * LINE_W / 8) + 32'(s * LINE_W / 8));
                    exp_data.push_back(lines[w][s]);
                    exp_tags[w][s][TAG_W-2] = 1'b0;
                    if (inv) exp_tags[w][s][TAG_W-1] = 1'b0;
                end else if (t[TAG_W-1] && inv) begin
                    n_ci++;
                    exp_tags[w][s][TAG_W-1] = 1'b0;
                end
            end
        exp_done = N + 1 + n_dirty * (d + 1) + n_ci;
        ack_d = d;
        stray = st;
        chk_wr = 1'b1;
        cyc = 0; n_busy = 0; n_done = 0; n_en = 0; done_at = -1; run = 0;
        @(negedge clk);
        flush_req_i = 1'b1;
        flush_inv_i = inv;
        step();
        flush_req_i = 1'b0;
        flush_inv_i = 1'($urandom);
        while (cyc < exp_done + 3) begin
            if (second && cyc == 5) flush_req_i = 1'b1;
            step();
            flush_req_i = 1'b0;
        end
        stray = 1'b0;
        mem_ack_i = 1'b0;
        check({name, "_done_cycle"}, done_at, exp_done);
        check({name, "_done_pulses"}, n_done, 1);
        check({name, "_busy_cycles"}, n_busy, exp_done);
        check({name, "_enable_cycles"}, n_en, n_dirty * d);
        check({name, "_wb_count"}, wb_count_o, n_dirty);
        check({name, "_missing_writes"}, exp_addr.size(), 0);
        check({name, "_idle_busy"}, busy_o, 0);
        for (int w = 0; w < NUM_WAYS; w++)
            for (int s = 0; s < NUM_SETS; s++)
                check($sformatf("%s_tag_w%0d_s%0d", name, w, s), tags[w][s], exp_tags[w][s]);
    endtask
    task automatic check_reset_outputs(input string name);
        check({name, "_busy"}, busy_o, 0);
        check({name, "_done"}, done_o, 0);
        check({name, "_enable"}, mem_enable_o, 0);
        check({name, "_write"}, mem_write_o, 0);
        check({name, "_wb_count"}, wb_count_o, 0);
        check({name, "_tag_we"}, sram_tag_we_o, 0);
        check({name, "_tag_out"}, sram_tag_o, 0);
        check({name, "_idx_way"}, {sram_way_o, sram_idx_o}, 0);
        check({name, "_mem_addr"}, mem_addr_o, 0);
        check({name, "_mem_data"}, mem_data_o, 0);
    endtask
    initial begin
        int d2, b2, e2, nd2;
        fill(0, 0);
        step();
        step();
        check_reset_outputs("init_rst");
        rst_i = 1'b1;
        step();
        run_flush("clean", 1'b0, 3, 1'b0, 1'b0);
        fill(0, 0);
        tags[1][3] = {2'b11, 23'h000010};
        lines[1][3] = {8{32'hECFA_5A3C}};
        run_flush("single", 1'b0, 4, 1'b0, 1'b0);
        fill(0, 0);
        tags[0][0] = {2'b11, 23'h001abc};
        tags[1][15] = {2'b11, 23'h7f00ff};
        run_flush("pair", 1'b0, 10, 1'b0, 1'b0);
        fill(0, 0);
        tags[0][7] = {2'b10, 23'h0000aa};
        tags[1][2] = {2'b11, 23'h000055};
        run_flush("inv", 1'b1, 2, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            fill(60, 50);
            run_flush($sformatf("rnd%0d", i), 1'($urandom), $urandom_range(1, 6), 1'b1, 1'(i % 2));
        end
        fill(80, 70);
        chk_wr = 1'b0;
        ack_d = 6;
        n_done = 0;
        @(negedge clk);
        flush_req_i = 1'b1;
        step();
        flush_req_i = 1'b0;
        repeat (30) step();
        rst_i = 1'b0;
        step();
        check("rst_enable_next", mem_enable_o, 0);
        step();
        check_reset_outputs("mid_rst");
        rst_i = 1'b1;
        mem_ack_i = 1'b0;
        repeat (3) step();
        check("rst_no_done", n_done, 0);
        run_flush("post_rst", 1'b0, 2, 1'b1, 1'b0);
        d2 = -1; b2 = 0; e2 = 0; nd2 = 0;
        @(negedge clk);
        req2 = 1'b1;
        @(negedge clk);
        req2 = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (busy2) b2++;
            if (en2) e2++;
            if (done2) begin
                nd2++;
                d2 = c;
            end
            @(negedge clk);
        end
        check("w4s8_done_cycle", d2, 33);
        check("w4s8_done_pulses", nd2, 1);
        check("w4s8_busy_cycles", b2, 33);
        check("w4s8_enable", e2, 0);
        check("w4s8_wb_count", wb2, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
